// File: rtl/mmio_peripheral.sv
// -----------------------------------------------------------------------------
// mmio_peripheral
//
// Memory-mapped peripheral block on the data side of the pipeline CPU. It
// decodes the MEM-stage load/store request against a 6-word register window
// at BASE_ADDR and provides:
//   - a reloading 32-bit timer (TH reload, TL counter, TCON control/status)
//     with a level interrupt request,
//   - an LED register driving the led port,
//   - a 7-segment digit register driving the digits port,
//   - a free-running 32-bit systick counter (read only).
//
// Register map (word index = addr[4:2], addr[1:0] ignored):
//   0 TH      RW 32       timer reload value
//   1 TL      RW 32       timer counter
//   2 TCON    RW 3        bit0 enable, bit1 irq enable, bit2 irq status
//   3 LED     RW LED_WIDTH
//   4 DIGITS  RW 12       [11:8] anode select, [7:0] segment pattern
//   5 SYSTICK RO 32       writes ignored
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   mem_read   in   MEM-stage load request
//   mem_write  in   MEM-stage store request
//   addr       in   32-bit byte address
//   wdata      in   32-bit store data
//   rdata      out  32-bit load data (combinational, 0 unless a load hits)
//   hit        out  addr lies inside the register window (combinational)
//   led        out  LED register
//   digits     out  DIGITS register
//   irq        out  TCON[1] & TCON[2]
//
// Request semantics: there is no handshake back-pressure. A request is
// qualified only by hit. A load (mem_read & hit) returns the current register
// value in the same cycle. A store (mem_write & hit) commits at the next rising
// edge. A load and a store in the same cycle see the pre-store value. Requests
// with hit=0 have no effect and return rdata=0.
// -----------------------------------------------------------------------------
module mmio_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 hit,
    output logic [LED_WIDTH-1:0] led,
    output logic [11:0]          digits,
    output logic                 irq
);

    // Word indices inside the window.
    localparam logic [2:0] IDX_TH      = 3'd0;
    localparam logic [2:0] IDX_TL      = 3'd1;
    localparam logic [2:0] IDX_TCON    = 3'd2;
    localparam logic [2:0] IDX_LED     = 3'd3;
    localparam logic [2:0] IDX_DIGITS  = 3'd4;
    localparam logic [2:0] IDX_SYSTICK = 3'd5;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [31:0]          r_th;
    logic [31:0]          r_tl;
    logic [2:0]           r_tcon;
    logic [LED_WIDTH-1:0] r_led;
    logic [11:0]          r_digits;
    logic [31:0]          r_systick;

    // -------------------------------------------------------------------------
    // Address decode and write strobes
    // -------------------------------------------------------------------------
    logic [2:0] w_idx;
    logic       w_in_page;
    logic       w_hit;
    logic       w_wr;
    logic       w_rd;
    logic       w_wr_th;
    logic       w_wr_tl;
    logic       w_wr_tcon;
    logic       w_wr_led;
    logic       w_wr_digits;

    // Byte offset within a word carries no meaning for this block.
    logic       w_unused_addr_lsb;
    assign w_unused_addr_lsb = &{1'b0, addr[1:0]};

    always_comb begin
        w_idx       = addr[4:2];
        // The window is 32 bytes aligned, but only indices 0..5 exist.
        w_in_page   = (addr[31:5] == BASE_ADDR[31:5]);
        w_hit       = w_in_page && (w_idx <= IDX_SYSTICK);
        w_wr        = mem_write && w_hit;
        w_rd        = mem_read  && w_hit;
        w_wr_th     = w_wr && (w_idx == IDX_TH);
        w_wr_tl     = w_wr && (w_idx == IDX_TL);
        w_wr_tcon   = w_wr && (w_idx == IDX_TCON);
        w_wr_led    = w_wr && (w_idx == IDX_LED);
        w_wr_digits = w_wr && (w_idx == IDX_DIGITS);
        // SYSTICK has no write strobe: stores to it are dropped.
    end

    // -------------------------------------------------------------------------
    // Timer next-state
    //
    // w_wrap       : counter is enabled and sits at all-ones this cycle, so it
    //                reloads from the current (old) TH at the edge.
    // w_ovf_event  : a wrap with interrupts enabled; sets the status bit.
    // -------------------------------------------------------------------------
    logic        w_tmr_en;
    logic        w_wrap;
    logic        w_ovf_event;
    logic [31:0] w_tl_next;
    logic [2:0]  w_tcon_next;

    always_comb begin
        w_tmr_en    = r_tcon[0];
        w_wrap      = w_tmr_en && (r_tl == TL_MAX);
        w_ovf_event = w_wrap && r_tcon[1];
    end

    // A CPU store to TL takes priority over both increment and reload.
    always_comb begin
        w_tl_next = r_tl;
        if (w_wr_tl) begin
            w_tl_next = wdata;
        end else if (w_tmr_en) begin
            if (w_wrap) begin
                w_tl_next = r_th;
            end else begin
                w_tl_next = r_tl + 32'd1;
            end
        end
    end

    // A store to TCON sets the control bits directly, but the status bit is
    // OR-ed with a same-cycle overflow so the event is never lost.
    always_comb begin
        w_tcon_next = r_tcon;
        if (w_wr_tcon) begin
            w_tcon_next[1:0] = wdata[1:0];
            w_tcon_next[2]   = wdata[2] | w_ovf_event;
        end else if (w_ovf_event) begin
            w_tcon_next[2] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State update. Reset wins over every store and timer event.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_tcon    <= '0;
            r_led     <= '0;
            r_digits  <= '0;
            r_systick <= '0;
        end else begin
            // TH is written after the reload value was sampled, so a store in
            // the wrap cycle only affects the next reload.
            if (w_wr_th) begin
                r_th <= wdata;
            end
            r_tl   <= w_tl_next;
            r_tcon <= w_tcon_next;
            if (w_wr_led) begin
                r_led <= wdata[LED_WIDTH-1:0];
            end
            if (w_wr_digits) begin
                r_digits <= wdata[11:0];
            end
            r_systick <= r_systick + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Read path (combinational, zero-extended narrow registers)
    // -------------------------------------------------------------------------
    logic [31:0] w_led_ext;
    logic [31:0] w_rdata;

    always_comb begin
        w_led_ext                = '0;
        w_led_ext[LED_WIDTH-1:0] = r_led;
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_idx)
                IDX_TH:      w_rdata = r_th;
                IDX_TL:      w_rdata = r_tl;
                IDX_TCON:    w_rdata = {29'b0, r_tcon};
                IDX_LED:     w_rdata = w_led_ext;
                IDX_DIGITS:  w_rdata = {20'b0, r_digits};
                IDX_SYSTICK: w_rdata = r_systick;
                default:     w_rdata = '0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rdata  = w_rdata;
    assign hit    = w_hit;
    assign led    = r_led;
    assign digits = r_digits;
    assign irq    = r_tcon[1] & r_tcon[2];

endmodule

// File: doc/mmio_peripheral.md
Name: mmio_peripheral

Overview:
Memory-mapped peripheral responder on the data side of the pipeline CPU. It answers the CPU's MEM-stage load/store requests (mem_read, mem_write, address, write data) for the address window at BASE_ADDR. It contains:
- a reloading 32-bit timer with an interrupt request,
- an LED register,
- a 7-segment digit register,
- a free-running systick counter.
The data-memory mux selects rdata when hit=1.

Parameters:
BASE_ADDR, 32'h4000_0000, base of the 6-word register window
LED_WIDTH, 8, width of the LED register and of the led port

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  MEM-stage load request
mem_write  input  1  MEM-stage store request
addr  input  32  byte address from the ALU result in MEM
wdata  input  32  store data
rdata  output  32  load data, combinational
hit  output  1  addr is inside the window, combinational
led  output  LED_WIDTH  LED register value
digits  output  12  [11:8] anode select, [7:0] segment pattern
irq  output  1  timer interrupt request = TCON[1] & TCON[2]

Behaviour:
- Register map. Word index = addr[4:2]; addr[1:0] is ignored. hit=1 iff addr[31:5]==BASE_ADDR[31:5] and addr[4:2]<=5.
  - 0: TH, RW 32, reload value
  - 1: TL, RW 32, counter
  - 2: TCON, RW 3 bits
    - bit0: timer enable
    - bit1: interrupt enable
    - bit2: interrupt status
    - reads return {29'b0, TCON}
  - 3: LED, RW, LED_WIDTH bits; reads are zero-extended
  - 4: DIGITS, RW, 12 bits; reads are zero-extended
  - 5: SYSTICK, RO 32; writes are ignored
- Reset: TH, TL, TCON, LED, DIGITS and SYSTICK all clear to 0 at the first rising edge with reset=1. Consequently led=0, digits=0, irq=0. Reset asserted mid-count overrides every other update in that cycle.
- Writes: when mem_write=1 and hit=1, the target register takes wdata at the next rising edge. Writes with hit=0 are dropped.
- Reads: combinational; no clock latency.
  - rdata shows the current register value when mem_read=1 and hit=1.
  - Otherwise rdata=0.
  - If mem_read=1 and mem_write=1 in the same cycle, rdata shows the pre-write value and the write commits at the edge.
- SYSTICK: increments by 1 every cycle when reset=0. It wraps from 32'hFFFF_FFFF to 0.
- Timer, evaluated each cycle when TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1 (overflow event).
  - Otherwise TL<=TL+1.
  - When TCON[0]=0, TL holds its value.
- Simultaneous events:
  - A CPU write to TL beats the timer update, including the reload.
  - A CPU write to TCON sets bits 1:0 from wdata. TCON[2] is then computed as (wdata[2] | overflow_event), so an overflow in the same cycle can never be lost.
  - A CPU write to TH in the overflow cycle does not affect that reload; the reload uses the old TH.
- irq is a level signal, not a pulse. It stays high until software clears TCON[2] or TCON[1].
- Clearing TCON[0] while TL is mid-count freezes TL; setting TCON[0] again resumes from the frozen value.

Test Plan:
1. Reset, then 10 idle cycles, then read 0x40000014 -> rdata=10 (±1 for the edge alignment the bench fixes); led=0, digits=0, irq=0.
2. Write TH=0xFFFF_FFFD, TL=0xFFFF_FFFD, TCON=3 -> TL reads FFFF_FFFE, then FFFF_FFFF. On the third cycle after enable, TL reloads to FFFF_FFFD and irq rises. irq stays 1 until a write of TCON=3, after which irq=0 on the next cycle.
3. Write TCON=3 in the exact cycle an overflow occurs -> TCON reads 7 and irq=1 (status is preserved).
4. Write 0xA5 to 0x4000000C and 0xF3F to 0x40000010 -> led=0xA5, digits=0xF3F. Write to 0x40000018 -> hit=0, no register changes, and a read there returns 0.
5. Simultaneous mem_read and mem_write to TH (old value 5, wdata 9) -> rdata=5 in that cycle; the following read returns 9. A write to SYSTICK is ignored.
6. Assert reset while the timer is running with irq=1 -> all registers read 0 and irq=0 on the next cycle; the counter stays frozen until TCON is re-enabled.
